// File: rtl/fll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fll_pkg
// Description : Shared types and constants for the FLL frequency controller.
//               Provides the controller state encoding, the mid-scale starting
//               code for the SAR search, and the default code width.
// Revision    : 1.0 - initial release
// ============================================================================
package fll_pkg;

  // Default width of the oscillator code (fixed at 5 in this revision).
  localparam int CODE_W_DEF = 5;

  // Mid-scale code: the SAR search always starts from here.
  localparam logic [4:0] FLL_CODE_MID = 5'b10000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    SEARCH = 2'd2,
    TRACK  = 2'd3
  } fll_state_t;

endpackage
`default_nettype wire

// File: rtl/fll_gray2bin.sv
`default_nettype none
// ============================================================================
// Module      : fll_gray2bin
// Description : Combinational Gray-to-binary converter.
// Ports       : gray - Gray-coded input value, CNT_W bits
//               bin  - binary equivalent, CNT_W bits
// Revision    : 1.0 - initial release
// ============================================================================
module fll_gray2bin #(
  parameter int CNT_W = 12
) (
  input  logic [CNT_W-1:0] gray,
  output logic [CNT_W-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it. Written as a
  // reduction per bit so no bit depends on another output bit.
  genvar i;
  generate
    for (i = 0; i < CNT_W; i++) begin : g_bit
      assign bin[i] = ^gray[CNT_W-1:i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fll_freq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fll_freq_ctrl
// Description : Digital frequency-locking controller. Measures oscillator
//               edges per window from a synchronized Gray-coded counter,
//               runs a 5-step SAR search on the oscillator code, then +/-1
//               tracking, and flags lock after LOCK_CNT in-tolerance windows.
// Ports       : clk_ref      - reference clock (only clock)
//               rst          - synchronous active-high reset
//               en           - control loop enable
//               win_len      - window length in clk_ref cycles (0 acts as 1)
//               target       - expected oscillator edges per window
//               osc_cnt_gray - free-running Gray oscillator count, synchronized
//               freq_control - oscillator code (higher = faster)
//               lock         - loop locked
//               meas_valid   - one-cycle pulse after each completed window
//               meas_delta   - edge count of the last completed window
// Revision    : 1.0 - initial release
// ============================================================================
module fll_freq_ctrl
  import fll_pkg::*;
#(
  parameter int CNT_W    = 12,
  parameter int WIN_W    = 8,
  parameter int CODE_W   = CODE_W_DEF,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 4
) (
  input  logic              clk_ref,
  input  logic              rst,
  input  logic              en,
  input  logic [WIN_W-1:0]  win_len,
  input  logic [CNT_W-1:0]  target,
  input  logic [CNT_W-1:0]  osc_cnt_gray,
  output logic [CODE_W-1:0] freq_control,
  output logic              lock,
  output logic              meas_valid,
  output logic [CNT_W-1:0]  meas_delta
);

  localparam int IDX_W = $clog2(CODE_W);
  localparam int LC_W  = $clog2(LOCK_CNT + 1);

  // Tolerance bounds are computed one bit wider so the floor/saturation
  // decisions cannot be fooled by wrap-around.
  localparam logic [CNT_W:0] TOL_EXT = (CNT_W+1)'(TOL);
  localparam logic [CNT_W:0] MAX_EXT = {1'b0, {CNT_W{1'b1}}};

  fll_state_t         state, state_nxt;
  logic [CODE_W-1:0]  code_nxt;
  logic               lock_nxt;
  logic               valid_nxt;
  logic [CNT_W-1:0]   delta_nxt;
  logic [LC_W-1:0]    lock_cnt, lock_cnt_nxt;
  logic [WIN_W-1:0]   win_cnt, win_cnt_nxt;
  logic [CNT_W-1:0]   prev, prev_nxt;
  logic [IDX_W-1:0]   bit_idx, bit_idx_nxt;

  logic [CNT_W-1:0]   cur_bin;
  logic [CNT_W-1:0]   delta;
  logic [WIN_W-1:0]   reload;
  logic [CNT_W:0]     lo_bound;
  logic [CNT_W:0]     hi_sum;
  logic [CNT_W:0]     hi_bound;
  logic [CNT_W:0]     delta_ext;
  logic [CNT_W:0]     target_ext;

  fll_gray2bin #(
    .CNT_W (CNT_W)
  ) u_gray2bin (
    .gray (osc_cnt_gray),
    .bin  (cur_bin)
  );

  // Modulo subtraction absorbs counter wrap; windows hold < 2^CNT_W edges.
  assign delta      = cur_bin - prev;
  // A zero window length behaves like one cycle: reload value 0.
  assign reload     = (win_len == '0) ? '0 : (win_len - WIN_W'(1));

  assign delta_ext  = {1'b0, delta};
  assign target_ext = {1'b0, target};
  assign lo_bound   = (target_ext >= TOL_EXT) ? (target_ext - TOL_EXT) : '0;
  assign hi_sum     = target_ext + TOL_EXT;
  assign hi_bound   = (hi_sum > MAX_EXT) ? MAX_EXT : hi_sum;

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state        <= IDLE;
      freq_control <= FLL_CODE_MID;
      lock         <= 1'b0;
      meas_valid   <= 1'b0;
      meas_delta   <= '0;
      lock_cnt     <= '0;
      win_cnt      <= '0;
      prev         <= '0;
      bit_idx      <= IDX_W'(CODE_W - 1);
    end else begin
      state        <= state_nxt;
      freq_control <= code_nxt;
      lock         <= lock_nxt;
      meas_valid   <= valid_nxt;
      meas_delta   <= delta_nxt;
      lock_cnt     <= lock_cnt_nxt;
      win_cnt      <= win_cnt_nxt;
      prev         <= prev_nxt;
      bit_idx      <= bit_idx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    code_nxt     = freq_control;
    lock_nxt     = lock;
    valid_nxt    = 1'b0;
    delta_nxt    = meas_delta;
    lock_cnt_nxt = lock_cnt;
    win_cnt_nxt  = win_cnt;
    prev_nxt     = prev;
    bit_idx_nxt  = bit_idx;

    if (!en) begin
      // Disable wins over any window-end update; code is simply held.
      state_nxt = IDLE;
      lock_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          lock_nxt  = 1'b0;
          state_nxt = START;
        end

        START: begin
          prev_nxt     = cur_bin;
          code_nxt     = FLL_CODE_MID;
          bit_idx_nxt  = IDX_W'(CODE_W - 1);
          win_cnt_nxt  = reload;
          lock_cnt_nxt = '0;
          lock_nxt     = 1'b0;
          state_nxt    = SEARCH;
        end

        SEARCH, TRACK: begin
          if (win_cnt != '0) begin
            win_cnt_nxt = win_cnt - WIN_W'(1);
          end else begin
            // Window-end edge: close this window and open the next at once.
            win_cnt_nxt = reload;
            prev_nxt    = cur_bin;
            delta_nxt   = delta;
            valid_nxt   = 1'b1;

            if (state == SEARCH) begin
              if (delta > target) begin
                code_nxt[bit_idx] = 1'b0;
              end
              if (bit_idx != '0) begin
                code_nxt[bit_idx - IDX_W'(1)] = 1'b1;
                bit_idx_nxt = bit_idx - IDX_W'(1);
              end else begin
                state_nxt = TRACK;
              end
            end else begin
              if (delta_ext > hi_bound) begin
                code_nxt     = (freq_control == '0) ? '0 : (freq_control - CODE_W'(1));
                lock_cnt_nxt = '0;
                lock_nxt     = 1'b0;
              end else if (delta_ext < lo_bound) begin
                code_nxt     = (&freq_control) ? freq_control : (freq_control + CODE_W'(1));
                lock_cnt_nxt = '0;
                lock_nxt     = 1'b0;
              end else begin
                if (lock_cnt != LC_W'(LOCK_CNT)) begin
                  lock_cnt_nxt = lock_cnt + LC_W'(1);
                end
                lock_nxt = (lock_cnt_nxt == LC_W'(LOCK_CNT));
              end
            end
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fll_freq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fll_freq_ctrl
// Description : Self-checking bench for fll_freq_ctrl. A simple oscillator
//               plant (slope*code + offset edges per window) closes the loop;
//               a reference model predicts each window's result, which is
//               queued when the window's edges are injected and compared when
//               meas_valid pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fll_freq_ctrl;

  localparam int TOL      = 2;
  localparam int LOCK_CNT = 4;

  logic        clk_ref = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  win_len;
  logic [11:0] target;
  logic [11:0] osc_cnt_gray;
  logic [4:0]  freq_control;
  logic        lock;
  logic        meas_valid;
  logic [11:0] meas_delta;

  always #5 clk_ref = ~clk_ref;

  fll_freq_ctrl dut (
    .clk_ref      (clk_ref),
    .rst          (rst),
    .en           (en),
    .win_len      (win_len),
    .target       (target),
    .osc_cnt_gray (osc_cnt_gray),
    .freq_control (freq_control),
    .lock         (lock),
    .meas_valid   (meas_valid),
    .meas_delta   (meas_delta)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Plant and reference-model state.
  int osc_bin;
  int slope;
  int offs;
  int m_code;
  int m_k;
  int m_lcnt;
  bit m_search;
  bit m_lock;
  int exp_len;

  typedef struct {
    int delta;
    int code;
    int lock;
    int len;
  } exp_t;

  exp_t sb[$];
  int   tried[$];
  int   exp_tried[5] = '{16, 24, 20, 18, 17};

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] to_gray(input logic [11:0] v);
    return v ^ (v >> 1);
  endfunction

  function automatic void model_step(input int d);
    int lo;
    int hi;
    int t;
    t = int'(target);
    if (m_search) begin
      if (d > t) m_code = m_code & ~(1 << m_k);
      if (m_k > 0) begin
        m_code = m_code | (1 << (m_k - 1));
        m_k--;
      end else begin
        m_search = 1'b0;
      end
    end else begin
      lo = (t >= TOL) ? t - TOL : 0;
      hi = (t + TOL > 4095) ? 4095 : t + TOL;
      if (d > hi) begin
        m_code = (m_code == 0) ? 0 : m_code - 1;
        m_lcnt = 0;
      end else if (d < lo) begin
        m_code = (m_code == 31) ? 31 : m_code + 1;
        m_lcnt = 0;
      end else if (m_lcnt < LOCK_CNT) begin
        m_lcnt++;
      end
      m_lock = (m_lcnt == LOCK_CNT);
    end
  endfunction

  // Raise en and step to the first SEARCH cycle; model restarts the search.
  task automatic start_loop();
    @(negedge clk_ref);
    en = 1'b1;
    @(negedge clk_ref);
    @(negedge clk_ref);
    check("start_code", int'(freq_control), 16);
    check("start_valid", int'(meas_valid), 0);
    check("start_lock", int'(lock), 0);
    m_code   = 16;
    m_k      = 4;
    m_lcnt   = 0;
    m_lock   = 1'b0;
    m_search = 1'b1;
    sb.delete();
    tried.delete();
    exp_len  = (win_len == 0) ? 1 : int'(win_len);
  endtask

  // Called in the first cycle of a window: inject this window's edges, queue
  // the prediction, then wait for meas_valid and compare.
  task automatic do_window(input int chg_at = -1, input int chg_val = 0);
    exp_t e;
    int   edges;
    int   waited;
    bit   got;
    edges = slope * int'(freq_control) + offs;
    tried.push_back(int'(freq_control));
    osc_bin      = (osc_bin + edges) % 4096;
    osc_cnt_gray = to_gray(osc_bin[11:0]);
    model_step(edges);
    e.delta = edges;
    e.code  = m_code;
    e.lock  = int'(m_lock);
    e.len   = exp_len;
    sb.push_back(e);
    waited = 0;
    got    = 1'b0;
    while (!got && waited < 400) begin
      @(negedge clk_ref);
      waited++;
      if (waited == chg_at) win_len = chg_val[7:0];
      if (meas_valid) got = 1'b1;
    end
    exp_len = (win_len == 0) ? 1 : int'(win_len);
    e = sb.pop_front();
    if (!got) begin
      check("window_timeout", waited, e.len);
    end else begin
      check("window_cycles", waited, e.len);
      check("meas_delta", int'(meas_delta), e.delta);
      check("freq_control", int'(freq_control), e.code);
      check("lock", int'(lock), e.lock);
    end
  endtask

  task automatic stop_loop();
    en = 1'b0;
    @(negedge clk_ref);
  endtask

  initial begin
    rst          = 1'b1;
    en           = 1'b0;
    win_len      = 8'd16;
    target       = 12'd74;
    slope        = 4;
    offs         = 10;
    osc_bin      = 100;
    osc_cnt_gray = to_gray(12'd100);
    repeat (3) @(negedge clk_ref);
    check("rst_code", int'(freq_control), 16);
    check("rst_lock", int'(lock), 0);
    check("rst_valid", int'(meas_valid), 0);
    check("rst_delta", int'(meas_delta), 0);
    rst = 1'b0;

    // Nominal search and lock.
    start_loop();
    for (int i = 0; i < 9; i++) begin
      do_window();
      if (i == 4) check("sar_result", int'(freq_control), 16);
      if (i == 7) check("no_lock_w8", int'(lock), 0);
      if (i == 8) check("lock_w9", int'(lock), 1);
    end
    for (int i = 0; i < 5; i++) check("sar_tried", tried[i], exp_tried[i]);
    do_window();
    check("locked_delta", int'(meas_delta), 74);

    // Drift after lock.
    offs = 18;
    do_window();
    check("drift_code1", int'(freq_control), 15);
    check("drift_unlock", int'(lock), 0);
    do_window();
    check("drift_code2", int'(freq_control), 14);
    for (int i = 0; i < 4; i++) begin
      do_window();
      if (i == 2) check("relock_early", int'(lock), 0);
    end
    check("relock", int'(lock), 1);
    check("relock_delta", int'(meas_delta), 74);

    // Disable while locked: lock drops, code held.
    stop_loop();
    check("dis_lock", int'(lock), 0);
    check("dis_code", int'(freq_control), 14);
    check("dis_valid", int'(meas_valid), 0);
    repeat (20) @(negedge clk_ref);
    check("dis_hold", int'(freq_control), 14);
    check("dis_novalid", int'(meas_valid), 0);
    start_loop();
    for (int i = 0; i < 9; i++) do_window();

    // Reset in the middle of a search.
    stop_loop();
    start_loop();
    do_window();
    do_window();
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk_ref);
    check("midrst_code", int'(freq_control), 16);
    check("midrst_lock", int'(lock), 0);
    check("midrst_valid", int'(meas_valid), 0);
    rst = 1'b0;

    // Saturation low.
    offs   = 10;
    target = 12'd0;
    start_loop();
    for (int i = 0; i < 9; i++) do_window();
    check("sat_lo_code", int'(freq_control), 0);
    check("sat_lo_lock", int'(lock), 0);

    // Saturation high.
    stop_loop();
    target = 12'd4095;
    start_loop();
    for (int i = 0; i < 9; i++) do_window();
    check("sat_hi_code", int'(freq_control), 31);
    check("sat_hi_lock", int'(lock), 0);

    // Counter wrap: 12 edges per window starting from 4090.
    stop_loop();
    osc_bin      = 4090;
    osc_cnt_gray = to_gray(12'd4090);
    target       = 12'd12;
    slope        = 0;
    offs         = 12;
    start_loop();
    do_window();
    check("wrap_delta", int'(meas_delta), 12);
    for (int i = 0; i < 8; i++) do_window();
    check("wrap_code", int'(freq_control), 31);
    check("wrap_lock", int'(lock), 1);

    // Zero window length: a window every cycle.
    stop_loop();
    slope   = 4;
    offs    = 10;
    target  = 12'd74;
    win_len = 8'd0;
    start_loop();
    for (int i = 0; i < 7; i++) do_window();

    // Window length change mid-window.
    stop_loop();
    win_len = 8'd16;
    start_loop();
    do_window(5, 8);
    do_window();
    do_window();
    check("winlen_now", int'(win_len), 8);

    stop_loop();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire
